shift_arbiter: RTL and testbench
================================

SHIFT_ARBITER -- requirements
Module: shift_arbiter

Interface
REQ-001 The block SHALL have no parameters; data width is fixed at 8 bits and shift amount at 3 bits.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset; synchronous and active-high.
REQ-004 req0_valid  input  1  requester 0 has a shift request.
REQ-005 req0_data  input  8  requester 0 operand.
REQ-006 req0_amt  input  3  requester 0 right-shift amount.
REQ-007 req0_ready  output  1  requester 0 request accepted this cycle.
REQ-008 req1_valid, req1_data, req1_amt, req1_ready SHALL mirror REQ-004..REQ-007 for requester 1.
REQ-009 out_valid  output  1  result register holds a valid result.
REQ-010 out_data  output  8  shifted result.
REQ-011 out_id  output  1  index of the requester that owns out_data.
REQ-012 out_ready  input  1  consumer accepts the result.

Function
REQ-013 The shift SHALL be logical right with zero fill: result = data >> amt; amt=0 passes data unchanged.
REQ-014 The datapath SHALL be one shared three-stage 2:1-mux shifter (stages of 4, 2 and 1), selected by the granted requester's operand and amount.
REQ-015 A request SHALL transfer when reqN_valid and reqN_ready are both high at a rising edge.
REQ-016 The slot SHALL be free when out_valid=0, or when out_valid=1 and out_ready=1 in the same cycle (drain and refill).
REQ-017 reqN_ready SHALL be high only when the slot is free, reqN_valid=1 and requester N holds the grant; at most one ready SHALL be high per cycle.
REQ-018 If only one requester is valid, it SHALL hold the grant.
REQ-019 Latency SHALL be exactly one cycle: a transfer at edge k SHALL leave out_valid=1 with out_data and out_id valid after edge k.
REQ-020 out_data and out_id SHALL stay stable while out_valid=1 and out_ready=0.
REQ-021 out_valid SHALL clear after an edge with out_valid=1, out_ready=1 and no transfer.
REQ-022 The controller SHALL use two states, EMPTY (out_valid=0) and FULL (out_valid=1): EMPTY->FULL on transfer; FULL->EMPTY on drain without transfer; FULL->FULL on stall, or on drain with transfer.
REQ-023 With sustained out_ready=1 and valid requests, throughput SHALL be one result per cycle.
REQ-024 Deasserting reqN_valid without a transfer SHALL be legal, and the block SHALL NOT record that request.

Reset
REQ-025 When rst=1 at an edge, the block SHALL set out_valid=0, out_data=8'h00 and out_id=0, and SHALL set the arbitration pointer so that requester 0 wins the next tie.
REQ-026 While rst=1, req0_ready and req1_ready SHALL be 0, and no transfer SHALL occur.
REQ-027 A reset asserted while FULL SHALL discard the held result with no handshake.

Configuration
REQ-028 With SHIFT_ARB_RR_EN defined, ties SHALL resolve round-robin: the requester not granted last wins, and the pointer SHALL update only on a transfer.
REQ-029 Without SHIFT_ARB_RR_EN, ties SHALL resolve by fixed priority to requester 0, and the block SHALL hold no pointer state.

Verification
REQ-030 Single request: after reset, req0 data=8'hB4 amt=3 with out_ready=1 -> next cycle out_valid=1, out_data=8'h16, out_id=0.
REQ-031 Boundaries: req1 data=8'hFF amt=0 -> 8'hFF with out_id=1; amt=7 -> 8'h01; data=8'h80 amt=7 -> 8'h01.
REQ-032 Back-pressure: hold out_ready=0 with req0 valid -> req0_ready=0, out_data stays unchanged; on out_ready=1, drain and refill in the same cycle.
REQ-033 Tie with SHIFT_ARB_RR_EN: both requesters valid continuously, out_ready=1 -> out_id sequence 0,1,0,1. Without SHIFT_ARB_RR_EN -> 0,0,0,0.
REQ-034 Reset mid-operation: assert rst while FULL with out_ready=0 -> next cycle out_valid=0, out_data=8'h00, and the first tie after reset goes to requester 0.
REQ-035 Randomized valid/ready on both sides, checked against a reference model: no lost or duplicated results, and at most one ready per cycle.

Source files
------------

// File: rtl/shift_arbiter_if.sv
// shift_arbiter_if -- request/result bundle for shift_arbiter.
//   req0_* / req1_* : two requesters (valid, 8-bit operand, 3-bit right-shift
//                     amount, ready back from the arbiter)
//   out_*           : single result slot (valid, 8-bit data, owner id, ready
//                     from the consumer)
// Modports:
//   master : requester/consumer side (drives requests and out_ready)
//   slave  : arbiter side (drives readies and the result)
interface shift_arbiter_if;
    logic       req0_valid;
    logic [7:0] req0_data;
    logic [2:0] req0_amt;
    logic       req0_ready;
    logic       req1_valid;
    logic [7:0] req1_data;
    logic [2:0] req1_amt;
    logic       req1_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_id;
    logic       out_ready;

    modport master (
        output req0_valid, req0_data, req0_amt,
        input  req0_ready,
        output req1_valid, req1_data, req1_amt,
        input  req1_ready,
        input  out_valid, out_data, out_id,
        output out_ready
    );

    modport slave (
        input  req0_valid, req0_data, req0_amt,
        output req0_ready,
        input  req1_valid, req1_data, req1_amt,
        output req1_ready,
        output out_valid, out_data, out_id,
        input  out_ready
    );
endinterface

// File: rtl/shift_arbiter.sv
// shift_arbiter -- two requesters share one logical-right shifter
// (three 2:1-mux stages of 4, 2 and 1) feeding a single result register.
// Ports:
//   clk  : clock, all state updates on the rising edge
//   rst  : synchronous active-high reset
//   bus  : shift_arbiter_if.slave (requests in, readies and result out)
// Configuration:
//   SHIFT_ARB_RR_EN defined   -> ties resolve round-robin (pointer updated
//                                only on a transfer, requester 0 first)
//   SHIFT_ARB_RR_EN undefined -> ties resolve to requester 0, no pointer
// Latency is one cycle; the slot drains and refills in the same cycle.
module shift_arbiter (
    input  logic           clk,
    input  logic           rst,
    shift_arbiter_if.slave bus
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] out_data_q, out_data_d;
    logic       out_id_q, out_id_d;

`ifdef SHIFT_ARB_RR_EN
    logic       ptr_q, ptr_d;
`endif

    logic       tie_pick;
    logic       grant_id;
    logic       slot_free;
    logic       ready0, ready1;
    logic       xfer;
    logic [7:0] sel_data;
    logic [2:0] sel_amt;
    logic [7:0] stg4, stg2, stg1;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= EMPTY;
            out_data_q <= '0;
            out_id_q   <= 1'b0;
`ifdef SHIFT_ARB_RR_EN
            ptr_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            out_data_q <= out_data_d;
            out_id_q   <= out_id_d;
`ifdef SHIFT_ARB_RR_EN
            ptr_q      <= ptr_d;
`endif
        end
    end

    // Output / datapath: grant, readies and the shared shifter
    always_comb begin
`ifdef SHIFT_ARB_RR_EN
        tie_pick = ptr_q;
`else
        tie_pick = 1'b0;
`endif
        if (bus.req0_valid && bus.req1_valid) begin
            grant_id = tie_pick;
        end else if (bus.req1_valid) begin
            grant_id = 1'b1;
        end else begin
            grant_id = 1'b0;
        end

        // A full slot is still free when the consumer takes it this cycle.
        slot_free = (state_q == EMPTY) || bus.out_ready;
        ready0    = !rst && slot_free && bus.req0_valid && !grant_id;
        ready1    = !rst && slot_free && bus.req1_valid &&  grant_id;
        xfer      = ready0 || ready1;

        sel_data  = grant_id ? bus.req1_data : bus.req0_data;
        sel_amt   = grant_id ? bus.req1_amt  : bus.req0_amt;
        stg4      = sel_amt[2] ? {4'b0000, sel_data[7:4]} : sel_data;
        stg2      = sel_amt[1] ? {2'b00,   stg4[7:2]}     : stg4;
        stg1      = sel_amt[0] ? {1'b0,    stg2[7:1]}     : stg2;
    end

    // Next-state
    always_comb begin
        state_d    = state_q;
        out_data_d = out_data_q;
        out_id_d   = out_id_q;
`ifdef SHIFT_ARB_RR_EN
        ptr_d      = ptr_q;
`endif
        case (state_q)
            EMPTY: begin
                if (xfer) begin
                    state_d = FULL;
                end
            end
            FULL: begin
                if (bus.out_ready && !xfer) begin
                    state_d = EMPTY;
                end
            end
            default: state_d = EMPTY;
        endcase

        if (xfer) begin
            out_data_d = stg1;
            out_id_d   = grant_id;
`ifdef SHIFT_ARB_RR_EN
            ptr_d      = !grant_id;
`endif
        end
    end

    assign bus.req0_ready = ready0;
    assign bus.req1_ready = ready1;
    assign bus.out_valid  = (state_q == FULL);
    assign bus.out_data   = out_data_q;
    assign bus.out_id     = out_id_q;

endmodule

// File: tb/tb_shift_arbiter.sv
// tb_shift_arbiter -- directed and randomized stimulus for shift_arbiter.
// Inputs change 1 ns after the rising edge; outputs are sampled on the
// falling edge. Accepted requests push their expected result onto a queue;
// the result register is compared against the queue head while it is valid.
module tb_shift_arbiter;

    typedef struct packed {
        logic       id;
        logic [7:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    shift_arbiter_if bus ();

    shift_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int   vectors     = 0;
    int   miscompares = 0;
    exp_t sb[$];
    logic m_full = 1'b0;
    logic m_ptr  = 1'b0;
    logic just_reset = 1'b0;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive, check at negedge, update model, advance edge.
    task automatic cyc(input logic r,
                       input logic v0, input logic [7:0] d0, input logic [2:0] a0,
                       input logic v1, input logic [7:0] d1, input logic [2:0] a1,
                       input logic ordy);
        logic g, free, e0, e1;
        logic [7:0] tmp;
        rst            = r;
        bus.req0_valid = v0; bus.req0_data = d0; bus.req0_amt = a0;
        bus.req1_valid = v1; bus.req1_data = d1; bus.req1_amt = a1;
        bus.out_ready  = ordy;
        @(negedge clk);

`ifdef SHIFT_ARB_RR_EN
        g = (v0 && v1) ? m_ptr : v1;
`else
        g = (v0 && v1) ? 1'b0 : v1;
`endif
        free = !m_full || ordy;
        e0 = !r && free && v0 && !g;
        e1 = !r && free && v1 &&  g;
        chk("req0_ready", {7'b0, bus.req0_ready}, {7'b0, e0});
        chk("req1_ready", {7'b0, bus.req1_ready}, {7'b0, e1});
        chk("out_valid",  {7'b0, bus.out_valid},  {7'b0, m_full});
        if (just_reset) begin
            chk("rst_out_data", bus.out_data, 8'h00);
            chk("rst_out_id",   {7'b0, bus.out_id}, 8'h00);
            just_reset = 1'b0;
        end
        if (m_full && sb.size() > 0) begin
            chk("out_data", bus.out_data, sb[0].data);
            chk("out_id",   {7'b0, bus.out_id}, {7'b0, sb[0].id});
        end

        if (r) begin
            sb.delete();
            m_full = 1'b0;
            m_ptr  = 1'b0;
            just_reset = 1'b1;
        end else begin
            if (m_full && ordy) void'(sb.pop_front());
            if (e0 || e1) begin
                tmp = e1 ? (d1 >> a1) : (d0 >> a0);
                sb.push_back('{id: e1, data: tmp});
                m_ptr  = !e1;
                m_full = 1'b1;
            end else if (m_full && ordy) begin
                m_full = 1'b0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.req0_valid = 1'b0; bus.req0_data = '0; bus.req0_amt = '0;
        bus.req1_valid = 1'b0; bus.req1_data = '0; bus.req1_amt = '0;
        bus.out_ready  = 1'b0;
        @(posedge clk);
        #1;

        // Reset, readies held low even with valid requests
        cyc(1, 1, 8'hAA, 3'd1, 1, 8'h55, 3'd2, 1);
        cyc(1, 0, 8'h00, 3'd0, 0, 8'h00, 3'd0, 0);

        // Single request: B4 >> 3 = 16, owner 0
        cyc(0, 1, 8'hB4, 3'd3, 0, 8'h00, 3'd0, 1);
        cyc(0, 0, 8'h00, 3'd0, 0, 8'h00, 3'd0, 1);

        // Boundaries on requester 1
        cyc(0, 0, 8'h00, 3'd0, 1, 8'hFF, 3'd0, 1);
        cyc(0, 0, 8'h00, 3'd0, 1, 8'hFF, 3'd7, 1);
        cyc(0, 0, 8'h00, 3'd0, 1, 8'h80, 3'd7, 1);
        cyc(0, 0, 8'h00, 3'd0, 0, 8'h00, 3'd0, 1);
        cyc(0, 0, 8'h00, 3'd0, 0, 8'h00, 3'd0, 1);

        // Back-pressure then drain-and-refill
        cyc(0, 1, 8'hC3, 3'd2, 0, 8'h00, 3'd0, 0);
        cyc(0, 1, 8'h7E, 3'd1, 0, 8'h00, 3'd0, 0);
        cyc(0, 1, 8'h7E, 3'd1, 0, 8'h00, 3'd0, 0);
        cyc(0, 1, 8'h7E, 3'd1, 0, 8'h00, 3'd0, 1);
        cyc(0, 0, 8'h00, 3'd0, 0, 8'h00, 3'd0, 1);
        cyc(0, 0, 8'h00, 3'd0, 0, 8'h00, 3'd0, 1);

        // Sustained tie
        for (int i = 0; i < 5; i++)
            cyc(0, 1, 8'h10 + 8'(i), 3'd1, 1, 8'hE0 + 8'(i), 3'd2, 1);
        cyc(0, 0, 8'h00, 3'd0, 0, 8'h00, 3'd0, 1);

        // Reset while FULL and stalled; first tie afterwards goes to 0
        cyc(0, 0, 8'h00, 3'd0, 1, 8'h9C, 3'd1, 0);
        cyc(0, 0, 8'h00, 3'd0, 0, 8'h00, 3'd0, 0);
        cyc(1, 0, 8'h00, 3'd0, 0, 8'h00, 3'd0, 0);
        cyc(0, 1, 8'h44, 3'd2, 1, 8'h88, 3'd3, 1);
        cyc(0, 0, 8'h00, 3'd0, 0, 8'h00, 3'd0, 1);

        // Withdrawn request is not recorded
        cyc(0, 0, 8'h00, 3'd0, 1, 8'h12, 3'd0, 0);
        cyc(0, 1, 8'h33, 3'd0, 0, 8'h00, 3'd0, 0);
        cyc(0, 0, 8'h00, 3'd0, 0, 8'h00, 3'd0, 1);
        cyc(0, 0, 8'h00, 3'd0, 0, 8'h00, 3'd0, 1);

        // Randomized valid/ready on both sides
        for (int i = 0; i < 300; i++)
            cyc(0, 1'($urandom), 8'($urandom), 3'($urandom),
                   1'($urandom), 8'($urandom), 3'($urandom),
                   1'($urandom_range(0, 3) != 0));

        // Flush: remaining result must match, then slot empties
        cyc(0, 0, 8'h00, 3'd0, 0, 8'h00, 3'd0, 1);
        cyc(0, 0, 8'h00, 3'd0, 0, 8'h00, 3'd0, 1);
        chk("sb_empty", 8'(sb.size()), 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
